// File: rtl/ibex_pmp_csr_if.sv
// ibex_pmp_csr_pkg / ibex_pmp_csr_if
//
// This file holds the shared PMP configuration types and the CSR access
// interface used by the PMP CSR bank.
//
// Package ibex_pmp_csr_pkg:
//   pmp_mode_e : address-matching mode (OFF, TOR, NA4, NAPOT).
//   pmp_cfg_t  : per-region configuration {lock, mode, exec, write, read}.
//
// Interface ibex_pmp_csr_if carries the CSR access signals:
//   csr_we_i    : write strobe, one cycle per write
//   csr_addr_i  : 12-bit CSR address for read and write
//   csr_wdata_i : final write data (CSRRW/S/C resolved upstream)
//   csr_rdata_o : combinational read data for csr_addr_i
//   csr_hit_o   : csr_addr_i falls in the PMP CSR range
// Modports:
//   slave  : the register bank side
//   master : the CSR file / requester side

package ibex_pmp_csr_pkg;

    typedef enum logic [1:0] {
        PMP_MODE_OFF   = 2'b00,
        PMP_MODE_TOR   = 2'b01,
        PMP_MODE_NA4   = 2'b10,
        PMP_MODE_NAPOT = 2'b11
    } pmp_mode_e;

    typedef struct packed {
        logic      lock;
        pmp_mode_e mode;
        logic      exec;
        logic      write;
        logic      read;
    } pmp_cfg_t;

endpackage

interface ibex_pmp_csr_if;

    logic        csr_we_i;
    logic [11:0] csr_addr_i;
    logic [31:0] csr_wdata_i;
    logic [31:0] csr_rdata_o;
    logic        csr_hit_o;

    modport slave (
        input  csr_we_i,
        input  csr_addr_i,
        input  csr_wdata_i,
        output csr_rdata_o,
        output csr_hit_o
    );

    modport master (
        output csr_we_i,
        output csr_addr_i,
        output csr_wdata_i,
        input  csr_rdata_o,
        input  csr_hit_o
    );

endinterface

// File: rtl/ibex_pmp_csr.sv
// ibex_pmp_csr
//
// PMP CSR register bank. Holds pmpcfg0-3 and pmpaddr0-15, applies lock and
// WARL legalisation to CSR writes and drives the registered configuration
// consumed by the PMP access checker.
//
// Parameters:
//   PMPGranularity : NAPOT granularity G (0 = 4 B, 1 = 8 B, ...)
//   PMPNumRegions  : implemented regions, 1..16
//
// Ports:
//   clk_i          : clock
//   rst_i          : synchronous active-high reset
//   csr            : CSR access interface (slave modport)
//   csr_pmp_cfg_o  : registered per-region configuration
//   csr_pmp_addr_o : registered per-region address {pmpaddr, 2'b00}
//   pmp_cfg_upd_o  : one-cycle pulse after a write that changed state
//   shadow_err_o   : sticky primary/shadow mismatch flag
//
// Optional feature: define IBEX_PMP_CSR_SHADOW_EN to keep an inverted shadow
// copy of every stored field; otherwise shadow_err_o is tied low.

module ibex_pmp_csr
    import ibex_pmp_csr_pkg::*;
#(
    parameter int unsigned PMPGranularity = 0,
    parameter int unsigned PMPNumRegions  = 4
) (
    input  logic          clk_i,
    input  logic          rst_i,
    ibex_pmp_csr_if.slave csr,
    output pmp_cfg_t      csr_pmp_cfg_o  [PMPNumRegions],
    output logic [33:0]   csr_pmp_addr_o [PMPNumRegions],
    output logic          pmp_cfg_upd_o,
    output logic          shadow_err_o
);

    // Bits forced to 0 on pmpaddr reads for OFF/TOR regions ([G-1:0]).
    localparam logic [31:0] GRAN_MASK =
        (PMPGranularity == 0) ? 32'h0 : ((32'h1 << PMPGranularity) - 32'h1);
    // Bits forced to 1 on pmpaddr reads for NAPOT regions ([G-2:0]).
    localparam logic [31:0] NAPOT_MASK =
        (PMPGranularity < 2) ? 32'h0 : ((32'h1 << (PMPGranularity - 1)) - 32'h1);

    pmp_cfg_t    cfg_q  [PMPNumRegions];
    pmp_cfg_t    cfg_d  [PMPNumRegions];
    logic [31:0] addr_q [PMPNumRegions];
    logic [31:0] addr_d [PMPNumRegions];

    logic                     is_cfg;
    logic                     is_addr;
    logic [PMPNumRegions-1:0] addr_lock;
    logic                     state_changed;
    logic                     upd_q;

    // Byte-wise WARL legalisation of a pmpcfg byte.
    function automatic pmp_cfg_t legalise_cfg(logic [7:0] b, pmp_cfg_t old);
        pmp_cfg_t n;
        n.lock  = b[7];
        n.mode  = pmp_mode_e'(b[4:3]);
        n.exec  = b[2];
        n.write = b[1] & b[0];
        n.read  = b[0];
        // NA4 is not selectable once the granule exceeds 4 bytes.
        if ((PMPGranularity >= 1) && (b[4:3] == 2'b10)) begin
            n.mode = old.mode;
        end
        return n;
    endfunction

    // Read-side view of a stored pmpaddr; the stored bits never change.
    function automatic logic [31:0] addr_read_val(logic [31:0] a, pmp_mode_e m);
        logic [31:0] v;
        v = a;
        if ((m == PMP_MODE_OFF) || (m == PMP_MODE_TOR)) begin
            v = a & ~GRAN_MASK;
        end else if (m == PMP_MODE_NAPOT) begin
            v = a | NAPOT_MASK;
        end
        return v;
    endfunction

    // Address decode: 0x3A0-0x3A3 (pmpcfg) and 0x3B0-0x3BF (pmpaddr).
    always_comb begin
        is_cfg  = (csr.csr_addr_i[11:2] == 10'h0E8);
        is_addr = (csr.csr_addr_i[11:4] == 8'h3B);
    end

    // pmpaddr r is frozen by its own lock, or by a locked TOR region r+1
    // which uses pmpaddr r as its lower bound.
    always_comb begin
        for (int unsigned r = 0; r < PMPNumRegions; r++) begin
            addr_lock[r] = cfg_q[r].lock;
        end
        for (int unsigned r = 1; r < PMPNumRegions; r++) begin
            if (cfg_q[r].lock && (cfg_q[r].mode == PMP_MODE_TOR)) begin
                addr_lock[r-1] = 1'b1;
            end
        end
    end

    // Next-state: each cfg byte is judged independently against its own lock.
    always_comb begin
        cfg_d  = cfg_q;
        addr_d = addr_q;
        for (int unsigned r = 0; r < PMPNumRegions; r++) begin
            if (csr.csr_we_i && is_cfg &&
                ((r >> 2) == 32'(csr.csr_addr_i[1:0])) && !cfg_q[r].lock) begin
                cfg_d[r] = legalise_cfg(csr.csr_wdata_i[8*(r%4) +: 8], cfg_q[r]);
            end
            if (csr.csr_we_i && is_addr &&
                (r == 32'(csr.csr_addr_i[3:0])) && !addr_lock[r]) begin
                addr_d[r] = csr.csr_wdata_i;
            end
        end
    end

    always_comb begin
        state_changed = 1'b0;
        for (int unsigned r = 0; r < PMPNumRegions; r++) begin
            if ((cfg_d[r] != cfg_q[r]) || (addr_d[r] != addr_q[r])) begin
                state_changed = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned r = 0; r < PMPNumRegions; r++) begin
                cfg_q[r]  <= '0;
                addr_q[r] <= '0;
            end
            upd_q <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < PMPNumRegions; r++) begin
                cfg_q[r]  <= cfg_d[r];
                addr_q[r] <= addr_d[r];
            end
            upd_q <= state_changed;
        end
    end

    // Read path: registered state only, so a same-cycle write is not bypassed.
    always_comb begin
        csr.csr_rdata_o = '0;
        csr.csr_hit_o   = is_cfg | is_addr;
        for (int unsigned r = 0; r < PMPNumRegions; r++) begin
            if (is_cfg && ((r >> 2) == 32'(csr.csr_addr_i[1:0]))) begin
                csr.csr_rdata_o[8*(r%4) +: 8] = {cfg_q[r].lock, 2'b00, cfg_q[r].mode,
                                                 cfg_q[r].exec, cfg_q[r].write,
                                                 cfg_q[r].read};
            end
            if (is_addr && (r == 32'(csr.csr_addr_i[3:0]))) begin
                csr.csr_rdata_o = addr_read_val(addr_q[r], cfg_q[r].mode);
            end
        end
    end

    always_comb begin
        for (int unsigned r = 0; r < PMPNumRegions; r++) begin
            csr_pmp_cfg_o[r]  = cfg_q[r];
            csr_pmp_addr_o[r] = {addr_q[r], 2'b00};
        end
        pmp_cfg_upd_o = upd_q;
    end

`ifdef IBEX_PMP_CSR_SHADOW_EN
    // Shadows are kept flat so a whole copy can be compared in one step.
    logic [6*PMPNumRegions-1:0]  cfg_sh_q;
    logic [32*PMPNumRegions-1:0] addr_sh_q;
    logic [6*PMPNumRegions-1:0]  cfg_flat;
    logic [32*PMPNumRegions-1:0] addr_flat;
    logic                        sh_mismatch;
    logic                        shadow_err_q;

    always_comb begin
        cfg_flat  = '0;
        addr_flat = '0;
        for (int unsigned r = 0; r < PMPNumRegions; r++) begin
            cfg_flat[6*r +: 6]   = cfg_q[r];
            addr_flat[32*r +: 32] = addr_q[r];
        end
        sh_mismatch = ((cfg_flat ^ cfg_sh_q) != '1) || ((addr_flat ^ addr_sh_q) != '1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cfg_sh_q     <= '1;
            addr_sh_q    <= '1;
            shadow_err_q <= 1'b0;
        end else begin
            for (int unsigned r = 0; r < PMPNumRegions; r++) begin
                cfg_sh_q[6*r +: 6]    <= ~cfg_d[r];
                addr_sh_q[32*r +: 32] <= ~addr_d[r];
            end
            shadow_err_q <= shadow_err_q | sh_mismatch;
        end
    end

    always_comb shadow_err_o = shadow_err_q;
`else
    always_comb shadow_err_o = 1'b0;
`endif

endmodule
